f124: RTL and testbench

F124 -- requirements
Module: f124

---
 rtl/f124.sv | 70 +++++++
 tb/tb_f124.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/f124.sv
// f124: 7442-style BCD decoder driving F = m1+m2+m4, a sticky non-BCD flag
// and a saturating hit counter. Define F124_REG_OUT_EN to register out.
module f124 #(
  parameter int CNT_W = 8
) (
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             out,
  input  logic             clk,
  input  logic             rst,
  output logic [9:0]       dec_n,
  output logic             bcd_err,
  output logic [CNT_W-1:0] hit_cnt
);

  logic [3:0] n;
  logic       f;
  logic       non_bcd;

  assign n       = {a, b, c, d};
  assign non_bcd = (n > 4'd9);

  // Active-low one-of-ten decode; codes 10..15 leave every line high
  always_comb begin
    dec_n = '1;
    case (n)
      4'd0:    dec_n[0] = 1'b0;
      4'd1:    dec_n[1] = 1'b0;
      4'd2:    dec_n[2] = 1'b0;
      4'd3:    dec_n[3] = 1'b0;
      4'd4:    dec_n[4] = 1'b0;
      4'd5:    dec_n[5] = 1'b0;
      4'd6:    dec_n[6] = 1'b0;
      4'd7:    dec_n[7] = 1'b0;
      4'd8:    dec_n[8] = 1'b0;
      4'd9:    dec_n[9] = 1'b0;
      default: dec_n = '1;
    endcase
  end

  // F is the NAND of the three selected decoder lines
  assign f = ~(dec_n[1] & dec_n[2] & dec_n[4]);

`ifdef F124_REG_OUT_EN
  // Registered result: one cycle behind the inputs, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= 1'b0;
    else     out <= f;
  end
`else
  assign out = f;
`endif

  // Sticky flag for any non-BCD code seen at a clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          bcd_err <= 1'b0;
    else if (non_bcd) bcd_err <= 1'b1;
  end

  // Count edges where F is true, holding at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hit_cnt <= '0;
    else if (f && (hit_cnt != {CNT_W{1'b1}}))
      hit_cnt <= hit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_f124.sv
// tb_f124: directed table sweep of f124 plus hand sequences for the
// sticky flag, counter saturation and reset behaviour.
module tb_f124;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a, b, c, d;
  logic       out, out_s;
  logic [9:0] dec_n, dec_s;
  logic       bcd_err, err_s;
  logic [7:0] hit_cnt;
  logic [1:0] cnt_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  f124 u_dut (
    .a(a), .b(b), .c(c), .d(d), .out(out),
    .clk(clk), .rst(rst),
    .dec_n(dec_n), .bcd_err(bcd_err), .hit_cnt(hit_cnt)
  );

  f124 #(.CNT_W(2)) u_sat (
    .a(a), .b(b), .c(c), .d(d), .out(out_s),
    .clk(clk), .rst(rst),
    .dec_n(dec_s), .bcd_err(err_s), .hit_cnt(cnt_s)
  );

  typedef struct {
    logic [3:0] n;
    logic       f;
    logic [9:0] dec;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_n(input logic [3:0] v);
    {a, b, c, d} = v;
  endtask

  task automatic edge_then_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{4'd0,  1'b0, 10'h3FE};
    vt[1]  = '{4'd1,  1'b1, 10'h3FD};
    vt[2]  = '{4'd2,  1'b1, 10'h3FB};
    vt[3]  = '{4'd3,  1'b0, 10'h3F7};
    vt[4]  = '{4'd4,  1'b1, 10'h3EF};
    vt[5]  = '{4'd5,  1'b0, 10'h3DF};
    vt[6]  = '{4'd6,  1'b0, 10'h3BF};
    vt[7]  = '{4'd7,  1'b0, 10'h37F};
    vt[8]  = '{4'd8,  1'b0, 10'h2FF};
    vt[9]  = '{4'd9,  1'b0, 10'h1FF};
    vt[10] = '{4'd10, 1'b0, 10'h3FF};
    vt[11] = '{4'd11, 1'b0, 10'h3FF};
    vt[12] = '{4'd12, 1'b0, 10'h3FF};
    vt[13] = '{4'd13, 1'b0, 10'h3FF};
    vt[14] = '{4'd14, 1'b0, 10'h3FF};
    vt[15] = '{4'd15, 1'b0, 10'h3FF};

    // reset state, decoder and comb out live during reset
    set_n(4'd7);
    #3;
    chk("rst_err", bcd_err, 0);
    chk("rst_cnt", hit_cnt, 0);
    chk("rst_dec7", dec_n, 10'h37F);
    set_n(4'd2);
    #1;
`ifdef F124_REG_OUT_EN
    chk("rst_out_reg", out, 0);
`else
    chk("rst_out_live", out, 1);
`endif
    @(negedge clk);
    set_n(4'd0);
    rst = 1'b0;

    // exhaustive table sweep
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      set_n(vt[i].n);
      #1;
      chk($sformatf("dec_n[%0d]", i), dec_n, vt[i].dec);
`ifndef F124_REG_OUT_EN
      chk($sformatf("out[%0d]", i), out, vt[i].f);
`endif
      edge_then_settle();
`ifdef F124_REG_OUT_EN
      chk($sformatf("out_reg[%0d]", i), out, vt[i].f);
`endif
    end
    chk("sweep_cnt", hit_cnt, 3);
    chk("sweep_cnt_sat", cnt_s, 3);
    chk("sweep_err", bcd_err, 1);
    chk("sweep_err_sat", err_s, 1);
    chk("sweep_dec_sat", dec_s, 10'h3FF);
    chk("sweep_out_sat", out_s, 0);

    // sticky error flag
    @(negedge clk);
    rst = 1'b1;
    set_n(4'd3);
    #1;
    chk("pulse_err", bcd_err, 0);
    chk("pulse_cnt", hit_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) edge_then_settle();
    chk("err_n3", bcd_err, 0);
    @(negedge clk);
    set_n(4'd11);
    edge_then_settle();
    chk("err_n11", bcd_err, 1);
    @(negedge clk);
    set_n(4'd3);
    repeat (5) edge_then_settle();
    chk("err_hold", bcd_err, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("err_async_clr", bcd_err, 0);

    // saturation on the 2-bit instance, plain count on the 8-bit one
    @(negedge clk);
    set_n(4'd4);
    #1;
    chk("cnt_in_rst", hit_cnt, 0);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      edge_then_settle();
      chk($sformatf("sat_cnt%0d", i), cnt_s, (i > 3) ? 3 : i);
      chk($sformatf("cnt%0d", i), hit_cnt, i);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("cnt_async_clr", hit_cnt, 0);
    chk("sat_async_clr", cnt_s, 0);

    // out latency on 0->2 step and async clear mid-cycle
    @(negedge clk);
    rst = 1'b0;
    set_n(4'd0);
    edge_then_settle();
    @(negedge clk);
    set_n(4'd2);
    #1;
`ifdef F124_REG_OUT_EN
    chk("step_out_now", out, 0);
`else
    chk("step_out_now", out, 1);
`endif
    edge_then_settle();
    chk("step_out_next", out, 1);
    #2;
    rst = 1'b1;
    #1;
`ifdef F124_REG_OUT_EN
    chk("rst_out_clr", out, 0);
`else
    chk("rst_out_live2", out, 1);
`endif
    chk("rst_dec2", dec_n, 10'h3FB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
